sample_fetch_arbiter: RTL

Shares the single CPU-serviced SDRAM sample mailbox between two audio requesters: music channel 0 and sound-effect channel 1. It arbitrates round-robin and drives the mailbox request/acknowledge handshake that the NIOS reads and writes through the game register file (address, data, REQ/ACK/VLD flag bits). It returns each fetched byte to the granted channel. A timeout substitutes a silence sample when the CPU does not answer, so the I2S side never stalls.

---
 rtl/sample_fetch_arbiter_if.sv | 27 ++
 rtl/sample_fetch_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/sample_fetch_arbiter_if.sv
// Bundle of requester-side and CPU-mailbox-side signals for sample_fetch_arbiter.
// master = the arbiter itself, slave = requesters plus the CPU responder.
interface sample_fetch_arbiter_if;
  logic [1:0]  ch_req;
  logic [23:0] ch_addr0;
  logic [23:0] ch_addr1;
  logic [7:0]  ch_data;
  logic [1:0]  ch_done;
  logic        ch_err;
  logic [23:0] mbx_addr;
  logic        mbx_req;
  logic        mbx_ack;
  logic [7:0]  mbx_data;
  logic        mbx_valid;
  logic        busy;
  logic [7:0]  err_cnt;

  modport master (
    input  ch_req, ch_addr0, ch_addr1, mbx_data, mbx_valid,
    output ch_data, ch_done, ch_err, mbx_addr, mbx_req, mbx_ack, busy, err_cnt
  );

  modport slave (
    output ch_req, ch_addr0, ch_addr1, mbx_data, mbx_valid,
    input  ch_data, ch_done, ch_err, mbx_addr, mbx_req, mbx_ack, busy, err_cnt
  );
endinterface

// File: rtl/sample_fetch_arbiter.sv
// Round-robin arbiter sharing the CPU sample mailbox between two audio channels,
// with a timeout that returns a silence sample so the audio path never stalls.
//
// state | meaning
// IDLE  | waiting for a channel request with no stale mbx_valid pending
// REQ   | mbx_req raised, waiting for mbx_valid or timeout
// ACK   | mbx_ack raised, waiting for the CPU to drop mbx_valid
// DONE  | one-cycle ch_done pulse to the granted channel
module sample_fetch_arbiter #(
  parameter int          TIMEOUT = 50000,
  parameter logic [7:0]  SILENCE = 8'h80
) (
  input  logic                    clk,
  input  logic                    reset,
  sample_fetch_arbiter_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic             last_grant;
  logic             pick;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      mbx_addr;
  logic             mbx_req;
  logic             mbx_ack;
  logic [7:0]       ch_data;
  logic [1:0]       ch_done;
  logic             ch_err;
  logic [7:0]       err_cnt;
  logic [1:0]       grant_onehot;

  // A lone requester wins outright; on a tie the channel not served last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.ch_req == 2'b10)
      pick = 1'b1;
    else if (bus.ch_req == 2'b11)
      pick = ~last_grant;
  end

  assign grant_onehot = last_grant ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      mbx_addr   <= '0;
      mbx_req    <= 1'b0;
      mbx_ack    <= 1'b0;
      ch_data    <= '0;
      ch_done    <= '0;
      ch_err     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      ch_done <= '0;
      case (state)
        IDLE: begin
          // A high mbx_valid here is a late answer to a fetch that already timed out.
          if ((bus.ch_req != 2'b00) && !bus.mbx_valid) begin
            last_grant <= pick;
            mbx_addr   <= pick ? bus.ch_addr1 : bus.ch_addr0;
            mbx_req    <= 1'b1;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.mbx_valid) begin
            ch_data <= bus.mbx_data;
            ch_err  <= 1'b0;
            mbx_req <= 1'b0;
            mbx_ack <= 1'b1;
            state   <= ACK;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ch_data <= SILENCE;
            ch_err  <= 1'b1;
            mbx_req <= 1'b0;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
            ch_done <= grant_onehot;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          if (!bus.mbx_valid) begin
            mbx_ack <= 1'b0;
            ch_done <= grant_onehot;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mbx_addr = mbx_addr;
  assign bus.mbx_req  = mbx_req;
  assign bus.mbx_ack  = mbx_ack;
  assign bus.ch_data  = ch_data;
  assign bus.ch_done  = ch_done;
  assign bus.ch_err   = ch_err;
  assign bus.err_cnt  = err_cnt;
  assign bus.busy     = (state != IDLE);

endmodule
